// File: rtl/alu_share_arbiter_if.sv
// Request and response channels between the two ALU requesters/consumer and the
// shared-ALU arbiter.
interface alu_share_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic                  r0_valid;
    logic                  r0_ready;
    logic [DATA_WIDTH-1:0] r0_src1;
    logic [DATA_WIDTH-1:0] r0_src2;
    logic [3:0]            r0_op;
    logic                  r1_valid;
    logic                  r1_ready;
    logic [DATA_WIDTH-1:0] r1_src1;
    logic [DATA_WIDTH-1:0] r1_src2;
    logic [3:0]            r1_op;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_id;
    logic [DATA_WIDTH-1:0] rsp_result;
    logic                  rsp_zero;

    modport master (
        output r0_valid, r0_src1, r0_src2, r0_op,
        output r1_valid, r1_src1, r1_src2, r1_op,
        output rsp_ready,
        input  r0_ready, r1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero
    );

    modport slave (
        input  r0_valid, r0_src1, r0_src2, r0_op,
        input  r1_valid, r1_src1, r1_src2, r1_op,
        input  rsp_ready,
        output r0_ready, r1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_zero
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters, with a
// registered issue stage and a backpressured, id-tagged response register.
module alu_share_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SLOW_LAT   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    alu_share_arbiter_if.slave    bus,
    output logic [DATA_WIDTH-1:0] alu_src1,
    output logic [DATA_WIDTH-1:0] alu_src2,
    output logic [3:0]            alu_op,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_zero,
    output logic                  busy
);
    typedef enum logic [0:0] {StIdle, StExec} state_e;

    localparam logic [2:0] SlowCnt = 3'(SLOW_LAT);

    state_e                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  iss_id_q, iss_id_d;
    logic [DATA_WIDTH-1:0] src1_q, src1_d;
    logic [DATA_WIDTH-1:0] src2_q, src2_d;
    logic [3:0]            op_q, op_d;
    logic                  last_grant_q, last_grant_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_id_q, rsp_id_d;
    logic [DATA_WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic                  rsp_zero_q, rsp_zero_d;

    logic                  iss_v;
    logic                  retire;
    logic                  can_accept;
    logic                  grant0;
    logic                  grant1;
    logic                  accept;
    logic                  sel;
    logic [3:0]            sel_op;
    logic [DATA_WIDTH-1:0] sel_src1;
    logic [DATA_WIDTH-1:0] sel_src2;

    // Shift and compare ops hold the issue stage for SLOW_LAT extra cycles.
    function automatic logic is_slow(input logic [3:0] op);
        return (op >= 4'd5) && (op <= 4'd9);
    endfunction

    assign iss_v      = (state_q == StExec);
    assign retire     = iss_v && (cnt_q == 3'd0) && (!rsp_valid_q || bus.rsp_ready);
    assign can_accept = rst_n && !flush && (!iss_v || retire);

    // With both requesting, the one not granted last time wins.
    assign grant0 = bus.r0_valid && (!bus.r1_valid || last_grant_q);
    assign grant1 = bus.r1_valid && (!bus.r0_valid || !last_grant_q);

    assign bus.r0_ready = grant0 && can_accept;
    assign bus.r1_ready = grant1 && can_accept;
    assign accept       = bus.r0_ready || bus.r1_ready;
    assign sel          = bus.r1_ready;
    assign sel_op       = sel ? bus.r1_op   : bus.r0_op;
    assign sel_src1     = sel ? bus.r1_src1 : bus.r0_src1;
    assign sel_src2     = sel ? bus.r1_src2 : bus.r0_src2;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        iss_id_d     = iss_id_q;
        src1_d       = src1_q;
        src2_d       = src2_q;
        op_d         = op_q;
        last_grant_d = last_grant_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;

        unique case (state_q)
            StIdle: begin
                if (accept) state_d = StExec;
            end
            StExec: begin
                if (retire && !accept) state_d = StIdle;
                else if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
            end
            default: state_d = StIdle;
        endcase

        if (accept) begin
            iss_id_d     = sel;
            src1_d       = sel_src1;
            src2_d       = sel_src2;
            op_d         = sel_op;
            cnt_d        = is_slow(sel_op) ? SlowCnt : 3'd0;
            last_grant_d = sel;
        end

        if (flush) begin
            state_d     = StIdle;
            cnt_d       = 3'd0;
            rsp_valid_d = 1'b0;
        end else if (retire) begin
            rsp_valid_d  = 1'b1;
            rsp_id_d     = iss_id_q;
            rsp_result_d = alu_result;
            rsp_zero_d   = alu_zero;
        end else if (bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= 3'd0;
            iss_id_q     <= 1'b0;
            src1_q       <= '0;
            src2_q       <= '0;
            op_q         <= 4'd0;
            last_grant_q <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            iss_id_q     <= iss_id_d;
            src1_q       <= src1_d;
            src2_q       <= src2_d;
            op_q         <= op_d;
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
        end
    end

    assign alu_src1       = src1_q;
    assign alu_src2       = src2_q;
    assign alu_op         = op_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_zero   = rsp_zero_q;
    assign busy           = iss_v || rsp_valid_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: a behavioural ALU feeds the DUT and a
// scoreboard of expected {id, zero, result} entries checks every response.
module tb_alu_share_arbiter;
    localparam logic [3:0] OpAdd = 4'h0;
    localparam logic [3:0] OpSub = 4'h1;
    localparam logic [3:0] OpOr  = 4'h3;
    localparam logic [3:0] OpSll = 4'h5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] alu_src1, alu_src2, alu_result;
    logic [3:0]  alu_op;
    logic        alu_zero;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [67:0] q0[$];
    logic [67:0] q1[$];
    logic [33:0] sb[$];
    logic        h0 = 1'b0;
    logic        h1 = 1'b0;

    alu_share_arbiter_if #(.DATA_WIDTH(32)) bus ();

    alu_share_arbiter #(
        .DATA_WIDTH(32),
        .SLOW_LAT  (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .bus       (bus),
        .alu_src1  (alu_src1),
        .alu_src2  (alu_src2),
        .alu_op    (alu_op),
        .alu_result(alu_result),
        .alu_zero  (alu_zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        case (op)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a & b;
            4'h3: return a | b;
            4'h4: return a ^ b;
            4'h5: return a << b[4:0];
            4'h6: return a >> b[4:0];
            4'h7: return $unsigned($signed(a) >>> b[4:0]);
            4'h8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'h9: return (a < b) ? 32'd1 : 32'd0;
            4'hA: return a;
            4'hB: return b;
            default: return 32'd0;
        endcase
    endfunction

    assign alu_result = alu_f(alu_op, alu_src1, alu_src2);
    assign alu_zero   = (alu_result == 32'd0);

    function automatic logic [33:0] expect_of(input logic id, input logic [67:0] r);
        logic [31:0] res;
        res = alu_f(r[67:64], r[63:32], r[31:0]);
        return {id, (res == 32'd0), res};
    endfunction

    function automatic logic [67:0] mk(input logic [3:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        return {op, a, b};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_true(input string tag, input logic cond);
        n_checks++;
        assert (cond === 1'b1) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x1", tag, cond);
        end
    endtask

    // Scoreboard: push on accepted request, pop on response handshake; flush and
    // reset drop everything in flight.
    always @(negedge clk) begin
        logic [33:0] e;
        if (!rst_n || flush) begin
            sb.delete();
        end else begin
            if (bus.rsp_valid && bus.rsp_ready) begin
                chk_true("rsp_expected", sb.size() != 0);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("sb_rsp_id", bus.rsp_id, e[33]);
                    chk("sb_rsp_zero", bus.rsp_zero, e[32]);
                    chk("sb_rsp_result", bus.rsp_result, e[31:0]);
                end
            end
            if (bus.r0_valid && bus.r0_ready) sb.push_back(expect_of(1'b0, q0[0]));
            if (bus.r1_valid && bus.r1_ready) sb.push_back(expect_of(1'b1, q1[0]));
        end
    end

    // Inputs change only at posedge+1; outputs are sampled at negedge.
    task automatic edge_step();
        @(posedge clk);
        #1;
        if (h0) q0.delete(0);
        if (h1) q1.delete(0);
        if (q0.size() != 0) begin
            {bus.r0_op, bus.r0_src1, bus.r0_src2} = q0[0];
            bus.r0_valid = 1'b1;
        end else begin
            bus.r0_valid = 1'b0;
        end
        if (q1.size() != 0) begin
            {bus.r1_op, bus.r1_src1, bus.r1_src2} = q1[0];
            bus.r1_valid = 1'b1;
        end else begin
            bus.r1_valid = 1'b0;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        h0 = bus.r0_valid && bus.r0_ready;
        h1 = bus.r1_valid && bus.r1_ready;
    endtask

    task automatic tick();
        edge_step();
        settle();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || busy || sb.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        chk_true("drain_in_budget", n < budget);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.r0_valid  = 1'b0;
        bus.r1_valid  = 1'b0;
        bus.r0_src1   = '0;
        bus.r0_src2   = '0;
        bus.r0_op     = '0;
        bus.r1_src1   = '0;
        bus.r1_src2   = '0;
        bus.r1_op     = '0;
        bus.rsp_ready = 1'b1;

        // Reset values
        repeat (3) tick();
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_id", bus.rsp_id, 0);
        chk("rst_rsp_result", bus.rsp_result, 0);
        chk("rst_rsp_zero", bus.rsp_zero, 0);
        chk("rst_alu_src1", alu_src1, 0);
        chk("rst_alu_src2", alu_src2, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_busy", busy, 0);
        q0.push_back(mk(OpAdd, 32'd5, 32'd7));
        tick();
        chk("ready_in_reset", bus.r0_ready, 0);

        // Single fast ADD: accept cycle 0, ALU cycle 1, response cycle 2
        edge_step();
        rst_n = 1'b1;
        settle();
        chk("add_r0_ready_c0", bus.r0_ready, 1);
        tick();
        chk("add_alu_src1_c1", alu_src1, 5);
        chk("add_alu_src2_c1", alu_src2, 7);
        chk("add_alu_op_c1", alu_op, OpAdd);
        chk("add_rsp_valid_c1", bus.rsp_valid, 0);
        chk("add_busy_c1", busy, 1);
        tick();
        chk("add_rsp_valid_c2", bus.rsp_valid, 1);
        chk("add_rsp_result_c2", bus.rsp_result, 12);
        chk("add_rsp_id_c2", bus.rsp_id, 0);
        chk("add_rsp_zero_c2", bus.rsp_zero, 0);
        drain(20);

        // SUB 3-3 from r1 gives zero flag
        q1.push_back(mk(OpSub, 32'd3, 32'd3));
        tick();
        chk("sub_r1_ready_c0", bus.r1_ready, 1);
        tick();
        tick();
        chk("sub_rsp_valid_c2", bus.rsp_valid, 1);
        chk("sub_rsp_zero_c2", bus.rsp_zero, 1);
        chk("sub_rsp_id_c2", bus.rsp_id, 1);
        drain(20);

        // Contention: grants alternate starting at r0, responses back to back
        for (int k = 0; k < 4; k++) begin
            q0.push_back(mk(OpAdd, 32'd10 + 32'(k), 32'd20));
            q1.push_back(mk(OpOr, 32'(k) << 8, 32'h0F));
        end
        tick();
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                chk("rr_r0_ready", bus.r0_ready, (i % 2) == 0);
                chk("rr_r1_ready", bus.r1_ready, (i % 2) == 1);
            end
            if (i >= 2) begin
                chk("rr_rsp_valid", bus.rsp_valid, 1);
                chk("rr_rsp_id", bus.rsp_id, (i % 2) == 1);
            end
            tick();
        end
        drain(20);

        // Slow SLL from r1; r0 request held from cycle 1 is accepted in cycle 2
        q1.push_back(mk(OpSll, 32'd1, 32'd4));
        tick();
        chk("slow_r1_ready_c0", bus.r1_ready, 1);
        q0.push_back(mk(OpAdd, 32'd2, 32'd2));
        tick();
        chk("slow_r0_blocked_c1", bus.r0_ready, 0);
        tick();
        chk("slow_r0_ready_c2", bus.r0_ready, 1);
        chk("slow_rsp_valid_c2", bus.rsp_valid, 0);
        tick();
        chk("slow_rsp_valid_c3", bus.rsp_valid, 1);
        chk("slow_rsp_result_c3", bus.rsp_result, 16);
        chk("slow_rsp_id_c3", bus.rsp_id, 1);
        tick();
        chk("slow_next_result_c4", bus.rsp_result, 4);
        drain(20);

        // Backpressure: rsp_ready low for 5 cycles with 3 queued ADDs
        for (int k = 0; k < 3; k++) q0.push_back(mk(OpAdd, 32'h100 + 32'(k), 32'(k)));
        edge_step();
        bus.rsp_ready = 1'b0;
        settle();
        chk("bp_r0_ready_c0", bus.r0_ready, 1);
        tick();
        chk("bp_r0_ready_c1", bus.r0_ready, 1);
        for (int c = 2; c <= 4; c++) begin
            tick();
            chk("bp_r0_ready_held", bus.r0_ready, 0);
            chk("bp_rsp_valid_held", bus.rsp_valid, 1);
            chk("bp_rsp_result_held", bus.rsp_result, 32'h100);
            chk("bp_alu_src1_stable", alu_src1, 32'h101);
        end
        edge_step();
        bus.rsp_ready = 1'b1;
        settle();
        drain(20);

        // Flush in cycle 1 of a slow op with the response register full
        q0.push_back(mk(OpAdd, 32'd1, 32'd1));
        edge_step();
        bus.rsp_ready = 1'b0;
        settle();
        chk("fl_r0_ready_c0", bus.r0_ready, 1);
        q1.push_back(mk(OpSll, 32'd2, 32'd3));
        tick();
        chk("fl_r1_ready_c1", bus.r1_ready, 1);
        q0.push_back(mk(OpAdd, 32'd9, 32'd1));
        edge_step();
        flush = 1'b1;
        bus.rsp_ready = 1'b1;
        settle();
        chk("fl_no_ready", bus.r0_ready, 0);
        chk("fl_rsp_full", bus.rsp_valid, 1);
        edge_step();
        flush = 1'b0;
        settle();
        chk("fl_rsp_valid_after", bus.rsp_valid, 0);
        chk("fl_busy_after", busy, 0);
        chk("fl_next_ready", bus.r0_ready, 1);
        tick();
        tick();
        chk("fl_next_rsp_valid", bus.rsp_valid, 1);
        chk("fl_next_rsp_result", bus.rsp_result, 10);
        drain(20);

        // Reset mid-op, then first contention must grant r0
        q0.push_back(mk(OpSll, 32'd3, 32'd2));
        tick();
        chk("mr_r0_ready_c0", bus.r0_ready, 1);
        edge_step();
        rst_n = 1'b0;
        settle();
        chk("mr_busy_in_exec", busy, 1);
        edge_step();
        rst_n = 1'b1;
        settle();
        chk("mr_rsp_valid", bus.rsp_valid, 0);
        chk("mr_busy", busy, 0);
        chk("mr_rsp_result", bus.rsp_result, 0);
        chk("mr_alu_src1", alu_src1, 0);
        chk("mr_alu_src2", alu_src2, 0);
        chk("mr_alu_op", alu_op, 0);
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("mr_no_rsp", bus.rsp_valid, 0);
        end
        q0.push_back(mk(OpAdd, 32'd4, 32'd4));
        q1.push_back(mk(OpAdd, 32'd6, 32'd6));
        tick();
        chk("mr_grant_r0", bus.r0_ready, 1);
        chk("mr_no_grant_r1", bus.r1_ready, 0);
        drain(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
